shift_pipe: RTL

- Parametrised, pipelined barrel-shift unit for the integer ALU lanes; successor to the fixed 32-bit combinational half-word shifter.
- Width, pipeline depth and tag width are configurable; adds a valid/ready handshake, backpressure stall, arithmetic-left overflow detection and an illegal-op flag.
- Sits between issue/operand-read and the result bus of a shift-capable functional unit.

---
 rtl/shift_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel-shift unit: stage 1 computes, stages 2..LAT are delay registers.
// A stalled output freezes the whole pipe, bubbles included.
module shift_pipe #(
  parameter int unsigned WID         = 64,
  parameter int unsigned LAT         = 2,
  parameter int unsigned TAGW        = 6,
  parameter bit          ROTATE_INSN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [2:0]               op,
  input  logic [WID-1:0]           a,
  input  logic [$clog2(WID)-1:0]   amt,
  input  logic [TAGW-1:0]          tag_i,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WID-1:0]           res,
  output logic                     ov,
  output logic                     err,
  output logic [TAGW-1:0]          tag_o
);

  localparam int unsigned AW = $clog2(WID);

  localparam logic [2:0] OpShl = 3'd0;
  localparam logic [2:0] OpShr = 3'd1;
  localparam logic [2:0] OpAsl = 3'd2;
  localparam logic [2:0] OpAsr = 3'd3;
  localparam logic [2:0] OpRol = 3'd4;
  localparam logic [2:0] OpRor = 3'd5;

  localparam logic [127:0]   DeadAll = {8{16'hDEAD}};
  localparam logic [WID-1:0] DeadPat = DeadAll[WID-1:0];

  logic [WID-1:0]   s1_res;
  logic             s1_ov;
  logic             s1_err;
  logic [2*WID-1:0] rol_w;
  logic [2*WID-1:0] ror_w;
  logic [AW-1:0]    top_sh;
  logic [WID-1:0]   top_bits;
  logic [WID-1:0]   top_ones;

  logic [LAT-1:0]  vld_q, vld_d;
  logic [WID-1:0]  res_q [LAT];
  logic [WID-1:0]  res_d [LAT];
  logic [LAT-1:0]  ov_q, ov_d;
  logic [LAT-1:0]  err_q, err_d;
  logic [TAGW-1:0] tag_q [LAT];
  logic [TAGW-1:0] tag_d [LAT];

  logic stall;

  assign rol_w = {a, a} << amt;
  assign ror_w = {a, a} >> amt;

  // The top amt+1 bits of a, right-justified; ASL overflows unless they are all equal.
  assign top_sh   = AW'(WID - 1) - amt;
  assign top_bits = a >> top_sh;
  assign top_ones = {WID{1'b1}} >> top_sh;

  always_comb begin
    s1_res = '0;
    s1_ov  = 1'b0;
    s1_err = 1'b0;
    case (op)
      OpShl: s1_res = a << amt;
      OpAsl: begin
        s1_res = a << amt;
        s1_ov  = (top_bits != '0) && (top_bits != top_ones);
      end
      OpShr: s1_res = a >> amt;
      OpAsr: s1_res = $unsigned($signed(a) >>> amt);
      OpRol: s1_res = ROTATE_INSN ? rol_w[2*WID-1 -: WID] : DeadPat;
      OpRor: s1_res = ROTATE_INSN ? ror_w[WID-1:0] : DeadPat;
      default: s1_err = 1'b1;
    endcase
  end

  assign stall  = vld_q[LAT-1] & ~out_rdy;
  assign in_rdy = ~stall;

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    ov_d  = ov_q;
    err_d = err_q;
    tag_d = tag_q;
    if (!stall) begin
      vld_d[0] = in_vld;
      if (in_vld) begin
        res_d[0] = s1_res;
        ov_d[0]  = s1_ov;
        err_d[0] = s1_err;
        tag_d[0] = tag_i;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        ov_d[i]  = ov_q[i-1];
        err_d[i] = err_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ov_q  <= '0;
      err_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ov_q  <= ov_d;
      err_q <= err_d;
      for (int i = 0; i < LAT; i++) begin
        res_q[i] <= res_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign res     = res_q[LAT-1];
  assign ov      = ov_q[LAT-1];
  assign err     = err_q[LAT-1];
  assign tag_o   = tag_q[LAT-1];

endmodule
